// File: rtl/seg_display_reader.sv
// Reads back an HH:MM:SS active-low 7-segment display, debounces it, validates
// every digit and rebuilds the total-seconds count with a shift-add accumulator.
module seg_display_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       HEX0,
    input  logic [6:0]       HEX1,
    input  logic [6:0]       HEX2,
    input  logic [6:0]       HEX3,
    input  logic [6:0]       HEX4,
    input  logic [6:0]       HEX5,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    input  logic             count_ready,
    output logic             err,
    output logic [2:0]       err_pos
);
    localparam int STAB_W = $clog2(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);

    typedef enum logic [2:0] {SAMPLE, DECODE, ACC1, ACC2, ACC3, OUT} state_t;

    state_t            state;
    logic [41:0]       hex_in;
    logic [41:0]       snap;
    logic [41:0]       last;
    logic [STAB_W-1:0] stab;
    logic              accepted;
    logic [5:0][3:0]   dreg;
    logic [CNT_W-1:0]  acc;
    logic [5:0][3:0]   dig;
    logic [5:0]        bad;
    logic [2:0]        bad_pos;

    function automatic logic [3:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'b1000000: seg_decode = 4'd0;
            7'b1111001: seg_decode = 4'd1;
            7'b0100100: seg_decode = 4'd2;
            7'b0110000: seg_decode = 4'd3;
            7'b0011001: seg_decode = 4'd4;
            7'b0010010: seg_decode = 4'd5;
            7'b0000010: seg_decode = 4'd6;
            7'b1111000: seg_decode = 4'd7;
            7'b0000000: seg_decode = 4'd8;
            7'b0010000: seg_decode = 4'd9;
            default:    seg_decode = 4'hF;
        endcase
    endfunction

    function automatic logic [STAB_W-1:0] sat_inc(input logic [STAB_W-1:0] v);
        return (v == STAB_MAX) ? v : v + STAB_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] ext(input logic [3:0] d);
        return CNT_W'(d);
    endfunction

    function automatic logic [CNT_W-1:0] mul10(input logic [CNT_W-1:0] x);
        return (x << 3) + (x << 1);
    endfunction

    function automatic logic [CNT_W-1:0] mul60(input logic [CNT_W-1:0] x);
        return (x << 5) + (x << 4) + (x << 3) + (x << 2);
    endfunction

    assign hex_in = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    // Tens of minutes and tens of seconds are also illegal above 5.
    always_comb begin
        dig     = '0;
        bad     = '0;
        bad_pos = 3'd0;
        for (int i = 0; i < 6; i++) begin
            dig[i] = seg_decode(snap[7*i +: 7]);
            bad[i] = (dig[i] == 4'hF) || ((i == 1 || i == 3) && (dig[i] > 4'd5));
        end
        for (int i = 5; i >= 0; i--) begin
            if (bad[i]) bad_pos = 3'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SAMPLE;
            snap        <= '0;
            stab        <= '0;
            accepted    <= 1'b0;
            count       <= '0;
            count_valid <= 1'b0;
            err         <= 1'b0;
            err_pos     <= 3'd0;
        end else begin
            err <= 1'b0;
            case (state)
                SAMPLE: begin
                    if (stab == STAB_MAX && (snap != last || !accepted)) begin
                        state <= DECODE;
                    end else begin
                        snap <= hex_in;
                        stab <= (hex_in != snap) ? '0 : sat_inc(stab);
                    end
                end
                DECODE: begin
                    accepted <= 1'b1;
                    if (|bad) begin
                        err     <= 1'b1;
                        err_pos <= bad_pos;
                        state   <= SAMPLE;
                    end else begin
                        state <= ACC1;
                    end
                end
                ACC1: state <= ACC2;
                ACC2: state <= ACC3;
                ACC3: begin
                    count       <= mul60(acc) + mul10(ext(dreg[1])) + ext(dreg[0]);
                    count_valid <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (count_ready) begin
                        count_valid <= 1'b0;
                        stab        <= '0;
                        state       <= SAMPLE;
                    end
                end
                default: state <= SAMPLE;
            endcase
        end
    end

    // Datapath registers carry no reset; they are only read in states that follow their load.
    always_ff @(posedge clk) begin
        case (state)
            DECODE: begin
                last <= snap;
                dreg <= dig;
            end
            ACC1:    acc <= mul10(ext(dreg[5])) + ext(dreg[4]);
            ACC2:    acc <= mul60(acc) + mul10(ext(dreg[3])) + ext(dreg[2]);
            default: ;
        endcase
    end
endmodule

// File: tb/tb_seg_display_reader.sv
// Randomised scoreboard bench for seg_display_reader: every display change is
// scored by a table-lookup reference model; a monitor checks each output.
module tb_seg_display_reader;
    localparam int S     = 4;
    localparam int CNT_W = 20;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [41:0]      disp;
    logic [CNT_W-1:0] count;
    logic             count_valid;
    logic             count_ready;
    logic             err;
    logic [2:0]       err_pos;

    always #5 clk = ~clk;

    seg_display_reader #(.STABLE_CYCLES(S), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .HEX0        (disp[6:0]),
        .HEX1        (disp[13:7]),
        .HEX2        (disp[20:14]),
        .HEX3        (disp[27:21]),
        .HEX4        (disp[34:28]),
        .HEX5        (disp[41:35]),
        .count       (count),
        .count_valid (count_valid),
        .count_ready (count_ready),
        .err         (err),
        .err_pos     (err_pos)
    );

    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    typedef struct {
        bit is_err;
        int val;
    } exp_t;

    exp_t        sb [$];
    int          tests = 0;
    int          fails = 0;
    int          ready_mode = 1;
    int          low_run = 0;
    bit          model_has = 0;
    logic [41:0] model_last = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic logic [41:0] mk(input int h1, input int h0, input int m1,
                                       input int m0, input int s1, input int s0);
        return {pat[h1], pat[h0], pat[m1], pat[m0], pat[s1], pat[s0]};
    endfunction

    // Reference: table lookup per digit, then hours*3600 + minutes*60 + seconds.
    function automatic void model(input logic [41:0] d, output bit is_err, output int val);
        int dg [6];
        is_err = 0;
        val    = 0;
        for (int i = 0; i < 6; i++) begin
            dg[i] = -1;
            for (int j = 0; j < 10; j++)
                if (d[7*i +: 7] == pat[j]) dg[i] = j;
        end
        for (int i = 5; i >= 0; i--) begin
            if (dg[i] < 0 || ((i == 1 || i == 3) && dg[i] > 5)) begin
                is_err = 1;
                val    = i;
            end
        end
        if (!is_err)
            val = (dg[5] * 10 + dg[4]) * 3600 + (dg[3] * 10 + dg[2]) * 60 + dg[1] * 10 + dg[0];
    endfunction

    function automatic logic [41:0] rand_disp();
        logic [41:0] v;
        int r;
        v = '0;
        for (int i = 0; i < 6; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      v[7*i +: 7] = 7'($urandom_range(0, 127));
            else if (r == 1) v[7*i +: 7] = pat[$urandom_range(0, 9)];
            else             v[7*i +: 7] = pat[$urandom_range(0, (i == 1 || i == 3) ? 5 : 9)];
        end
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [41:0] v);
        bit ie;
        int iv;
        exp_t e;
        disp = v;
        if (!model_has || v != model_last) begin
            model(v, ie, iv);
            e.is_err = ie;
            e.val    = iv;
            sb.push_back(e);
            model_last = v;
            model_has  = 1;
        end
    endtask

    task automatic issue(input logic [41:0] v, input int hold);
        drive(v);
        step(hold);
    endtask

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            1: count_ready = 1'b1;
            2: count_ready = 1'b0;
            default: begin
                if (low_run >= 3 || $urandom_range(0, 1) == 1) begin
                    count_ready = 1'b1;
                    low_run     = 0;
                end else begin
                    count_ready = 1'b0;
                    low_run++;
                end
            end
        endcase
    end

    exp_t             mon_e;
    bit               hold_pending = 0;
    logic [CNT_W-1:0] held_cnt;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 0;
        end else begin
            if (hold_pending) begin
                check("valid held while stalled", count_valid, 1);
                check("count held while stalled", count, held_cnt);
            end
            hold_pending = count_valid && !count_ready;
            held_cnt     = count;
            if (err || (count_valid && count_ready)) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected output: err=%0b count=%0d err_pos=%0d, required none",
                             err, count, err_pos);
                end else begin
                    mon_e = sb.pop_front();
                    check("output kind (1=err)", err, mon_e.is_err);
                    if (err) check("err_pos", err_pos, mon_e.val);
                    else     check("count", count, mon_e.val);
                end
            end
        end
    end

    initial begin
        int n;
        logic [41:0] v;
        logic [41:0] prev2;
        logic [41:0] cur;
        int r;

        disp        = mk(0, 0, 0, 0, 0, 0);
        count_ready = 1'b1;
        rst_n       = 1'b0;
        step(3);
        check("reset count", count, 0);
        check("reset count_valid", count_valid, 0);
        check("reset err", err, 0);
        check("reset err_pos", err_pos, 0);
        rst_n = 1'b1;

        issue(mk(0, 0, 0, 0, 0, 0), 40);

        drive(mk(0, 1, 0, 2, 0, 3));
        n = 0;
        do begin
            step(1);
            n++;
        end while (!count_valid && n < 50);
        check("latency 01:02:03", n, S + 5);
        step(30);

        issue(mk(9, 9, 5, 9, 5, 9), 40);
        issue(mk(0, 0, 0, 0, 5, 9), 40);

        drive(mk(0, 0, 0, 0, 6, 0));
        n = 0;
        do begin
            step(1);
            n++;
        end while (!err && n < 50);
        check("err latency", n, S + 2);
        step(1);
        check("err one cycle", err, 0);
        step(30);

        v = mk(0, 0, 0, 0, 6, 0);
        v[41:35] = 7'h7F;
        issue(v, 40);

        issue(mk(0, 0, 0, 0, 0, 0), 40);
        disp[6:0] = 7'b1111001;
        step(2);
        disp = mk(0, 0, 0, 0, 0, 0);
        step(30);

        ready_mode = 2;
        drive(mk(0, 0, 0, 1, 0, 0));
        n = 0;
        do begin
            step(1);
            n++;
        end while (!count_valid && n < 50);
        check("stall publish seen", count_valid, 1);
        drive(mk(0, 0, 0, 2, 0, 0));
        step(20);
        check("stalled count stays 60", count, 60);
        check("stalled valid stays high", count_valid, 1);
        ready_mode = 1;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!(count_valid && count == 120) && n < 60);
        check("release to 120 latency", n, S + 6);
        step(30);

        drive(mk(0, 0, 0, 3, 0, 0));
        step(S + 3);
        rst_n = 1'b0;
        #1;
        check("abort count", count, 0);
        check("abort count_valid", count_valid, 0);
        check("abort err", err, 0);
        check("abort err_pos", err_pos, 0);
        step(2);
        rst_n = 1'b1;
        step(40);

        ready_mode = 0;
        prev2 = disp;
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                cur  = disp;
                disp = cur ^ (42'd1 << $urandom_range(0, 41));
                step($urandom_range(1, S - 1));
                disp = cur;
                step(20);
            end else if (r < 3) begin
                v     = prev2;
                prev2 = disp;
                issue(v, 40);
            end else if (r < 4) begin
                issue(disp, 20);
            end else begin
                prev2 = disp;
                issue(rand_disp(), 40);
            end
        end

        ready_mode = 1;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            step(1);
            n++;
        end
        check("scoreboard drained", sb.size(), 0);
        step(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seg_display_reader.md
# seg_display_reader

Decodes six active-low 7-segment digit buses (HH:MM:SS layout, HEX5 = hour tens … HEX0 = second units) back into a total-seconds count. It is the receiving end of the clock display path: it samples the segment buses, debounces them, validates every digit, then rebuilds the count with a multi-cycle shift-add accumulator. The result is handed downstream over a valid/ready handshake. It serves as a loopback checker for the clock display and as the front end for any block that must read back the displayed time.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a display value is accepted (≥2).
- CNT_W, 20: width of `count`.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- HEX0..HEX5  in  7 each  segment patterns, active-low, bit0 = segment a … bit6 = segment g.
- count  out  CNT_W  reconstructed total seconds.
- count_valid  out  1  `count` holds an unconsumed result.
- count_ready  in  1  downstream accepts `count`.
- err  out  1  one-cycle pulse: accepted display value contains an illegal digit.
- err_pos  out  3  index (0–5) of the lowest-numbered illegal digit; valid while `err` = 1 and held until the next error.

## Operation
- Digit table (pattern→digit): 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9. Any other pattern, including blank 1111111, is illegal.
- Range check: HEX1 and HEX3 must decode to ≤5. A violation is illegal at that position.
- States: SAMPLE, DECODE, ACC1, ACC2, ACC3, OUT.
- SAMPLE:
  - `snap` ← {HEX5..HEX0} every cycle.
  - `stab` ← 0 when the input differs from `snap`, else `stab`+1 (saturating).
  - When `stab` = STABLE_CYCLES−1 and (`snap` ≠ `last`, or nothing has been accepted since reset), go to DECODE with `snap` frozen.
- DECODE:
  - Decode all six digits into registers d5..d0 and record `last` ← `snap`.
  - Any illegal digit: pulse `err`, load `err_pos`, return to SAMPLE.
  - Otherwise go to ACC1.
- ACC1: acc ← d5·10 + d4 (hours).
- ACC2: acc ← acc·60 + d3·10 + d2 (minutes).
- ACC3: acc ← acc·60 + d1·10 + d0, then go to OUT.
  - Multiplies by 10 and 60 use shifts and adds only.
  - Maximum result is 99:59:59 = 359999, which fits 20 bits; no wrap handling is needed.
- OUT:
  - `count` = acc and `count_valid` = 1, both held stable until the handshake.
  - On `count_valid` & `count_ready` at a rising edge, clear `count_valid` and return to SAMPLE with `stab` ← 0.
- Inputs are ignored in DECODE, ACC1–3 and OUT. A change arriving there is picked up after the return to SAMPLE.
- An unchanged display is never republished, and an illegal display reports `err` only once.
- Reset: state = SAMPLE, `count` = 0, `count_valid` = 0, `err` = 0, `err_pos` = 0, `stab` = 0, `snap` = 0, accept history cleared. A reset mid-operation aborts any conversion in progress and drops any unconsumed result.

## Timing
- New input value first sampled at edge k (S = STABLE_CYCLES):
  - DECODE is entered at edge k+S−1+1 = k+S.
  - ACC1 at k+S+1.
  - `count_valid` rises after edge k+S+4 (k+8 at the default S).
- `err` rises after edge k+S+1 and lasts exactly one cycle.
- Any input change before `stab` reaches S−1 restarts the window; a glitch shorter than S cycles produces no output.
- `count_ready` may be high before `count_valid`. The transfer then occurs at the first edge with both high, and `count_valid` is high for exactly one cycle.
- Throughput: at most one result per S+5 cycles.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset, all HEX = 1000000 for 10 cycles, `count_ready` = 1 → one `count_valid` pulse with `count` = 0, and no further pulses while the inputs are held.
- Display 01:02:03 → `count` = 3723, `count_valid` high 8 cycles after the first sample (S = 4).
- Display 99:59:59 → `count` = 359999; then 00:00:59 → 59.
- HEX1 = 0000010 (digit 6) → one `err` pulse, `err_pos` = 1, no `count_valid`. Then blank HEX5 with HEX1 = 6 still present → `err_pos` = 1, the lowest illegal index.
- From 00:00:00, HEX0 shows 1111001 for 2 cycles then reverts (S = 4) → no `count_valid`, no `err`.
- Hold `count_ready` = 0 with 00:01:00 published and change the display to 00:02:00 → `count` stays 60 and `count_valid` stays high. Raise `count_ready` → handshake completes, then `count` = 120 after S+5 cycles. Assert `rst_n` = 0 during ACC2 → all outputs 0 immediately.
